// File: rtl/reg_scoreboard_if.sv
// Decode / issue / writeback / squash bundle between the LC-3b pipeline and its
// register/CC scoreboard.
interface reg_scoreboard_if;
    logic       dec_valid;
    logic [2:0] dec_sr1;
    logic       dec_sr1_used;
    logic [2:0] dec_sr2;
    logic       dec_sr2_used;
    logic       dec_cc_used;
    logic       issue;
    logic [2:0] issue_dest;
    logic       issue_dest_we;
    logic       issue_cc_we;
    logic       wb_valid;
    logic [2:0] wb_dest;
    logic       wb_dest_we;
    logic       wb_cc_we;
    logic       squash_valid;
    logic [2:0] squash_dest;
    logic       squash_dest_we;
    logic       squash_cc_we;
    logic       dep_stall;
    logic [7:0] busy_mask;
    logic       cc_busy;
    logic       sb_error;

    modport master (
        output dec_valid, dec_sr1, dec_sr1_used, dec_sr2, dec_sr2_used, dec_cc_used,
        output issue, issue_dest, issue_dest_we, issue_cc_we,
        output wb_valid, wb_dest, wb_dest_we, wb_cc_we,
        output squash_valid, squash_dest, squash_dest_we, squash_cc_we,
        input  dep_stall, busy_mask, cc_busy, sb_error
    );

    modport slave (
        input  dec_valid, dec_sr1, dec_sr1_used, dec_sr2, dec_sr2_used, dec_cc_used,
        input  issue, issue_dest, issue_dest_we, issue_cc_we,
        input  wb_valid, wb_dest, wb_dest_we, wb_cc_we,
        input  squash_valid, squash_dest, squash_dest_we, squash_cc_we,
        output dep_stall, busy_mask, cc_busy, sb_error
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-writer scoreboard for R0-R7 and CC: counts in-flight writers per
// resource and raises dep_stall while a decode source still has one outstanding.
module reg_scoreboard #(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    reg_scoreboard_if.slave  sb
);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt [0:7];
    logic [CNT_W-1:0] r_cnt_cc;
    logic             r_sb_error;

    logic [8:0]       w_inc;
    logic [8:0]       w_dec_wb;
    logic [8:0]       w_dec_sq;
    logic [CNT_W-1:0] w_cnt_nxt [0:8];
    logic [8:0]       w_err;
    logic [7:0]       w_busy_rd;
    logic             w_cc_busy_rd;
    logic [7:0]       w_busy_mask;

    // Returns {error, next_count}; overflow holds the old count, underflow clamps to zero.
    function automatic logic [CNT_W:0] next_count(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic [1:0]       dec
    );
        logic [CNT_W+1:0] sum;
        logic [CNT_W+1:0] dec_ext;
        logic [CNT_W+1:0] res;
        logic [CNT_W:0]   out;
        sum     = {2'b00, cnt} + {{(CNT_W+1){1'b0}}, inc};
        dec_ext = {{CNT_W{1'b0}}, dec};
        res     = sum - dec_ext;
        if (dec_ext > sum) begin
            out = {1'b1, CNT_ZERO};
        end else if (res > {2'b00, {CNT_W{1'b1}}}) begin
            out = {1'b1, cnt};
        end else begin
            out = {1'b0, res[CNT_W-1:0]};
        end
        return out;
    endfunction

    // Per-resource increment/decrement strobes; index 8 is CC.
    always_comb begin
        w_inc    = 9'b0;
        w_dec_wb = 9'b0;
        w_dec_sq = 9'b0;
        for (int r = 0; r < 8; r++) begin
            w_inc[r]    = sb.issue & sb.issue_dest_we & (sb.issue_dest == 3'(r));
            w_dec_wb[r] = sb.wb_valid & sb.wb_dest_we & (sb.wb_dest == 3'(r));
            w_dec_sq[r] = sb.squash_valid & sb.squash_dest_we & (sb.squash_dest == 3'(r));
        end
        w_inc[8]    = sb.issue & sb.issue_cc_we;
        w_dec_wb[8] = sb.wb_valid & sb.wb_cc_we;
        w_dec_sq[8] = sb.squash_valid & sb.squash_cc_we;
    end

    // Next counts and per-resource error strobes.
    always_comb begin
        w_err = 9'b0;
        for (int r = 0; r < 9; r++) begin
            w_cnt_nxt[r] = CNT_ZERO;
        end
        for (int r = 0; r < 8; r++) begin
            {w_err[r], w_cnt_nxt[r]} = next_count(r_cnt[r], w_inc[r],
                                                  {1'b0, w_dec_wb[r]} + {1'b0, w_dec_sq[r]});
        end
        {w_err[8], w_cnt_nxt[8]} = next_count(r_cnt_cc, w_inc[8],
                                              {1'b0, w_dec_wb[8]} + {1'b0, w_dec_sq[8]});
    end

    // Reader view: a last writer retiring this cycle no longer blocks when bypass is on.
    always_comb begin
        w_busy_rd   = 8'b0;
        w_busy_mask = 8'b0;
        for (int r = 0; r < 8; r++) begin
            w_busy_mask[r] = (r_cnt[r] != CNT_ZERO);
            w_busy_rd[r]   = w_busy_mask[r] &
                             ~(WB_BYPASS & w_dec_wb[r] & (r_cnt[r] == CNT_ONE));
        end
        w_cc_busy_rd = (r_cnt_cc != CNT_ZERO) &
                       ~(WB_BYPASS & w_dec_wb[8] & (r_cnt_cc == CNT_ONE));
    end

    // Counter and sticky error state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 8; r++) begin
                r_cnt[r] <= CNT_ZERO;
            end
            r_cnt_cc   <= CNT_ZERO;
            r_sb_error <= 1'b0;
        end else begin
            for (int r = 0; r < 8; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
            r_cnt_cc   <= w_cnt_nxt[8];
            r_sb_error <= r_sb_error | (|w_err);
        end
    end

    assign sb.dep_stall = sb.dec_valid &
                          ((sb.dec_sr1_used & w_busy_rd[sb.dec_sr1]) |
                           (sb.dec_sr2_used & w_busy_rd[sb.dec_sr2]) |
                           (sb.dec_cc_used  & w_cc_busy_rd));
    assign sb.busy_mask = w_busy_mask;
    assign sb.cc_busy   = (r_cnt_cc != CNT_ZERO);
    assign sb.sb_error  = r_sb_error;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: the driver pushes model expectations per
// cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_scoreboard;
    localparam int CNT_W = 2;
    localparam int MAXC  = 3;
    localparam bit BYP   = 1'b1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_scoreboard_if sb_if();

    reg_scoreboard #(.CNT_W(CNT_W), .WB_BYPASS(BYP)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    typedef struct {
        logic       rst;
        logic       dv;
        logic [2:0] sr1;
        logic       u1;
        logic [2:0] sr2;
        logic       u2;
        logic       ucc;
        logic       load;
        logic [2:0] idest;
        logic       iwe;
        logic       icc;
        logic       wbv;
        logic [2:0] wbd;
        logic       wbwe;
        logic       wbcc;
        logic       sqv;
        logic [2:0] sqd;
        logic       sqwe;
        logic       sqcc;
    } stim_t;

    typedef struct {
        logic       stall;
        logic [7:0] mask;
        logic       ccb;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   model_cnt [0:8];
    bit   model_err;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0; s.dv = 1'b0; s.sr1 = 3'd0; s.u1 = 1'b0; s.sr2 = 3'd0; s.u2 = 1'b0;
        s.ucc = 1'b0; s.load = 1'b0; s.idest = 3'd0; s.iwe = 1'b0; s.icc = 1'b0;
        s.wbv = 1'b0; s.wbd = 3'd0; s.wbwe = 1'b0; s.wbcc = 1'b0;
        s.sqv = 1'b0; s.sqd = 3'd0; s.sqwe = 1'b0; s.sqcc = 1'b0;
        return s;
    endfunction

    // Resource r (8 = CC) blocks a reader if it has a writer pending, unless the
    // only pending writer retires right now and bypass is enabled.
    function automatic bit rd_busy(input int r, input stim_t s);
        bit retiring;
        if (r == 8) retiring = s.wbv && s.wbcc;
        else        retiring = s.wbv && s.wbwe && (int'(s.wbd) == r);
        return (model_cnt[r] != 0) && !(BYP && retiring && model_cnt[r] == 1);
    endfunction

    task automatic apply(input stim_t s);
        bit   stall;
        bit   iss;
        exp_t e;
        @(posedge clk);
        #1;
        stall = s.dv && ((s.u1 && rd_busy(int'(s.sr1), s)) ||
                         (s.u2 && rd_busy(int'(s.sr2), s)) ||
                         (s.ucc && rd_busy(8, s)));
        iss = s.dv && s.load && !stall;
        reset                 = s.rst;
        sb_if.dec_valid       = s.dv;
        sb_if.dec_sr1         = s.sr1;
        sb_if.dec_sr1_used    = s.u1;
        sb_if.dec_sr2         = s.sr2;
        sb_if.dec_sr2_used    = s.u2;
        sb_if.dec_cc_used     = s.ucc;
        sb_if.issue           = iss;
        sb_if.issue_dest      = s.idest;
        sb_if.issue_dest_we   = s.iwe;
        sb_if.issue_cc_we     = s.icc;
        sb_if.wb_valid        = s.wbv;
        sb_if.wb_dest         = s.wbd;
        sb_if.wb_dest_we      = s.wbwe;
        sb_if.wb_cc_we        = s.wbcc;
        sb_if.squash_valid    = s.sqv;
        sb_if.squash_dest     = s.sqd;
        sb_if.squash_dest_we  = s.sqwe;
        sb_if.squash_cc_we    = s.sqcc;
        e.stall = stall;
        for (int r = 0; r < 8; r++) e.mask[r] = (model_cnt[r] != 0);
        e.ccb = (model_cnt[8] != 0);
        e.err = model_err;
        exp_q.push_back(e);
        if (s.rst) begin
            for (int r = 0; r < 9; r++) model_cnt[r] = 0;
            model_err = 1'b0;
        end else begin
            for (int r = 0; r < 9; r++) begin
                int inc;
                int dec;
                int n;
                if (r == 8) begin
                    inc = (iss && s.icc) ? 1 : 0;
                    dec = ((s.wbv && s.wbcc) ? 1 : 0) + ((s.sqv && s.sqcc) ? 1 : 0);
                end else begin
                    inc = (iss && s.iwe && int'(s.idest) == r) ? 1 : 0;
                    dec = ((s.wbv && s.wbwe && int'(s.wbd) == r) ? 1 : 0) +
                          ((s.sqv && s.sqwe && int'(s.sqd) == r) ? 1 : 0);
                end
                n = model_cnt[r] + inc - dec;
                if (n < 0) begin
                    model_cnt[r] = 0;
                    model_err    = 1'b1;
                end else if (n > MAXC) begin
                    model_err = 1'b1;
                end else begin
                    model_cnt[r] = n;
                end
            end
        end
    endtask

    function automatic int pick_busy(input int start);
        for (int k = 0; k < 8; k++) begin
            if (model_cnt[(start + k) % 8] != 0) return (start + k) % 8;
        end
        return start;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int    r;
        s       = idle();
        s.rst   = ($urandom_range(63) == 0);
        s.dv    = ($urandom_range(3) != 0);
        s.sr1   = 3'($urandom_range(7));
        s.u1    = ($urandom_range(1) == 1);
        s.sr2   = 3'($urandom_range(7));
        s.u2    = ($urandom_range(1) == 1);
        s.ucc   = ($urandom_range(3) == 0);
        s.load  = ($urandom_range(3) != 0);
        s.idest = 3'($urandom_range(7));
        s.iwe   = ($urandom_range(9) < 7);
        s.icc   = ($urandom_range(4) < 2);
        s.wbv   = ($urandom_range(9) < 4);
        r       = pick_busy(int'($urandom_range(7)));
        s.wbd   = 3'(r);
        s.wbwe  = (model_cnt[r] != 0) || ($urandom_range(15) == 0);
        s.wbcc  = (model_cnt[8] != 0 && $urandom_range(1) == 1) || ($urandom_range(31) == 0);
        s.sqv   = ($urandom_range(9) < 2);
        r       = pick_busy(int'($urandom_range(7)));
        s.sqd   = 3'(r);
        s.sqwe  = (model_cnt[r] != 0) || ($urandom_range(15) == 0);
        s.sqcc  = (model_cnt[8] != 0 && $urandom_range(1) == 1) || ($urandom_range(31) == 0);
        return s;
    endfunction

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dep_stall", {7'b0, sb_if.dep_stall}, {7'b0, e.stall});
                check("busy_mask", sb_if.busy_mask, e.mask);
                check("cc_busy",   {7'b0, sb_if.cc_busy}, {7'b0, e.ccb});
                check("sb_error",  {7'b0, sb_if.sb_error}, {7'b0, e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        for (int r = 0; r < 9; r++) model_cnt[r] = 0;
        model_err = 1'b0;
        reset = 1'b1;
        sb_if.dec_valid = 1'b0; sb_if.dec_sr1 = 3'd0; sb_if.dec_sr1_used = 1'b0;
        sb_if.dec_sr2 = 3'd0; sb_if.dec_sr2_used = 1'b0; sb_if.dec_cc_used = 1'b0;
        sb_if.issue = 1'b0; sb_if.issue_dest = 3'd0; sb_if.issue_dest_we = 1'b0;
        sb_if.issue_cc_we = 1'b0; sb_if.wb_valid = 1'b0; sb_if.wb_dest = 3'd0;
        sb_if.wb_dest_we = 1'b0; sb_if.wb_cc_we = 1'b0; sb_if.squash_valid = 1'b0;
        sb_if.squash_dest = 3'd0; sb_if.squash_dest_we = 1'b0; sb_if.squash_cc_we = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, with a reader present.
        s = idle(); s.dv = 1'b1; s.u1 = 1'b1; s.sr1 = 3'd5; s.ucc = 1'b1;
        apply(s);
        @(negedge clk);
        check("rst_busy_mask", sb_if.busy_mask, 8'h00);
        check("rst_cc_busy",   {7'b0, sb_if.cc_busy}, 8'h00);
        check("rst_sb_error",  {7'b0, sb_if.sb_error}, 8'h00);
        check("rst_dep_stall", {7'b0, sb_if.dep_stall}, 8'h00);

        // Back-to-back RAW on R1, then bypassed retire.
        s = idle(); s.dv = 1'b1; s.load = 1'b1; s.iwe = 1'b1; s.idest = 3'd1;
        apply(s);
        s = idle(); s.dv = 1'b1; s.load = 1'b1; s.u1 = 1'b1; s.sr1 = 3'd1;
        s.u2 = 1'b1; s.sr2 = 3'd3; s.iwe = 1'b1; s.idest = 3'd2;
        apply(s);
        @(negedge clk);
        check("b2b_stall", {7'b0, sb_if.dep_stall}, 8'h01);
        check("b2b_mask",  sb_if.busy_mask, 8'h02);
        s.wbv = 1'b1; s.wbd = 3'd1; s.wbwe = 1'b1;
        apply(s);
        @(negedge clk);
        check("bypass_stall", {7'b0, sb_if.dep_stall}, 8'h00);
        s = idle(); s.u1 = 1'b1; s.sr1 = 3'd2;
        apply(s);
        @(negedge clk);
        check("retired_mask", sb_if.busy_mask, 8'h04);
        check("no_dv_stall",  {7'b0, sb_if.dep_stall}, 8'h00);
        s = idle(); s.wbv = 1'b1; s.wbd = 3'd2; s.wbwe = 1'b1;
        apply(s);

        // Simultaneous issue and retire on R4.
        s = idle(); s.dv = 1'b1; s.load = 1'b1; s.iwe = 1'b1; s.idest = 3'd4;
        apply(s);
        s.wbv = 1'b1; s.wbd = 3'd4; s.wbwe = 1'b1;
        apply(s);
        s = idle(); s.wbv = 1'b1; s.wbd = 3'd4; s.wbwe = 1'b1;
        apply(s);
        @(negedge clk);
        check("r4_mask", sb_if.busy_mask, 8'h10);
        check("r4_err",  {7'b0, sb_if.sb_error}, 8'h00);

        // CC hazard cleared by writeback, then by squash.
        s = idle(); s.dv = 1'b1; s.load = 1'b1; s.icc = 1'b1;
        apply(s);
        s = idle(); s.dv = 1'b1; s.load = 1'b1; s.ucc = 1'b1;
        repeat (2) begin
            apply(s);
            @(negedge clk);
            check("cc_stall", {7'b0, sb_if.dep_stall}, 8'h01);
        end
        s.wbv = 1'b1; s.wbcc = 1'b1;
        apply(s);
        @(negedge clk);
        check("cc_wb_stall", {7'b0, sb_if.dep_stall}, 8'h00);
        s = idle(); s.dv = 1'b1; s.load = 1'b1; s.icc = 1'b1;
        apply(s);
        s = idle(); s.sqv = 1'b1; s.sqcc = 1'b1;
        apply(s);
        @(negedge clk);
        check("cc_busy_pre_squash", {7'b0, sb_if.cc_busy}, 8'h01);
        apply(idle());
        @(negedge clk);
        check("cc_busy_squashed", {7'b0, sb_if.cc_busy}, 8'h00);

        // Saturation on R7, underflow on R0, then drain R7 and reset.
        s = idle(); s.dv = 1'b1; s.load = 1'b1; s.iwe = 1'b1; s.idest = 3'd7;
        repeat (4) apply(s);
        s = idle(); s.wbv = 1'b1; s.wbd = 3'd0; s.wbwe = 1'b1;
        apply(s);
        @(negedge clk);
        check("sat_err",  {7'b0, sb_if.sb_error}, 8'h01);
        check("sat_mask", sb_if.busy_mask, 8'h80);
        s = idle(); s.wbv = 1'b1; s.wbd = 3'd7; s.wbwe = 1'b1;
        repeat (3) apply(s);
        @(negedge clk);
        check("drain2_mask", sb_if.busy_mask, 8'h80);
        check("underflow_err", {7'b0, sb_if.sb_error}, 8'h01);
        apply(idle());
        @(negedge clk);
        check("drain3_mask", sb_if.busy_mask, 8'h00);
        s = idle(); s.rst = 1'b1;
        apply(s);
        apply(idle());
        @(negedge clk);
        check("reset_err", {7'b0, sb_if.sb_error}, 8'h00);

        // Reset mid-flight with a competing issue.
        s = idle(); s.dv = 1'b1; s.load = 1'b1; s.iwe = 1'b1; s.idest = 3'd2; s.icc = 1'b1;
        apply(s);
        s.icc = 1'b0;
        apply(s);
        s.rst = 1'b1;
        apply(s);
        s = idle(); s.dv = 1'b1; s.u1 = 1'b1; s.sr1 = 3'd2; s.ucc = 1'b1;
        apply(s);
        @(negedge clk);
        check("midrst_mask",  sb_if.busy_mask, 8'h00);
        check("midrst_cc",    {7'b0, sb_if.cc_busy}, 8'h00);
        check("midrst_stall", {7'b0, sb_if.dep_stall}, 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) apply(rand_stim());
        apply(idle());
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
